// File: rtl/i2s_sched_pkg.sv
// i2s_sched_pkg
//   Shared definitions for the I2S transmit scheduler.
//   - DEF_DATA_W      : default sample width
//   - ST_*            : scheduler FSM state encoding (exported on state_dbg)
//   - LEFT / RIGHT    : channel encoding; LEFT matches the tx_left=1 convention
//   - SRC_S0 / SRC_S1 : source index encoding used for grant and frame_src
package i2s_sched_pkg;

   localparam int DEF_DATA_W = 24;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WAIT_REQ = 2'd1;
   localparam logic [1:0] ST_FETCH    = 2'd2;
   localparam logic [1:0] ST_SEND     = 2'd3;

   localparam logic LEFT  = 1'b1;
   localparam logic RIGHT = 1'b0;

   localparam logic SRC_S0 = 1'b0;
   localparam logic SRC_S1 = 1'b1;

endpackage

// File: rtl/i2s_tx_sched_if.sv
// i2s_tx_sched_if
//   Bundles the source and serializer sides of the I2S transmit scheduler.
//   Parameter W : sample width.
//   Source side : s0_data/s0_valid/s0_ready, s1_data/s1_valid/s1_ready
//   Serializer  : tx_req (in), tx_data/tx_valid/tx_left/frame_src/underrun (out)
//   Modports    : master = scheduler, slave = surrounding sources/serializer.
//
// Handshake: a source sample is transferred in exactly the cycle where
// sx_valid && sx_ready are both high. Valid may be raised independently of
// ready; ready is only ever high for one cycle per slot (the FETCH cycle)
// and only for the source that owns the current frame. tx_valid is a
// one-cycle strobe with no back-pressure: the serializer must take tx_data
// in that cycle.
interface i2s_tx_sched_if
   import i2s_sched_pkg::*;
#(
   parameter int W = DEF_DATA_W
);
   logic [W-1:0] s0_data;
   logic         s0_valid;
   logic         s0_ready;
   logic [W-1:0] s1_data;
   logic         s1_valid;
   logic         s1_ready;
   logic         tx_req;
   logic [W-1:0] tx_data;
   logic         tx_valid;
   logic         tx_left;
   logic         frame_src;
   logic         underrun;

   modport master (
      input  s0_data, s0_valid, s1_data, s1_valid, tx_req,
      output s0_ready, s1_ready, tx_data, tx_valid, tx_left, frame_src, underrun
   );

   modport slave (
      output s0_data, s0_valid, s1_data, s1_valid, tx_req,
      input  s0_ready, s1_ready, tx_data, tx_valid, tx_left, frame_src, underrun
   );
endinterface

// File: rtl/i2s_src_arb.sv
// i2s_src_arb
//   Two-way source arbiter with a round-robin pointer register.
//   Ports:
//     clk, rst      : clock, synchronous active-low reset
//     rr_mode       : 0 = fixed priority (s0 first), 1 = round-robin
//     s0_valid/s1_valid : source availability
//     prev_grant    : grant of the previous frame, kept when nobody is valid
//     advance       : high in the cycle the frame grant is committed
//     grant         : selected source (combinational)
module i2s_src_arb
   import i2s_sched_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic rr_mode,
   input  logic s0_valid,
   input  logic s1_valid,
   input  logic prev_grant,
   input  logic advance,
   output logic grant
);

   logic ptr_q, ptr_d;
   logic pref_valid;
   logic other_valid;

   assign pref_valid  = (ptr_q == SRC_S1) ? s1_valid : s0_valid;
   assign other_valid = (ptr_q == SRC_S1) ? s0_valid : s1_valid;

   always_comb begin
      grant = prev_grant;
      if (rr_mode) begin
         if (pref_valid)       grant = ptr_q;
         else if (other_valid) grant = ~ptr_q;
      end else begin
         if (s0_valid)         grant = SRC_S0;
         else if (s1_valid)    grant = SRC_S1;
      end
   end

   // The preferred source flips once per frame, but only for frames that
   // actually went to a valid source; empty frames leave it untouched.
   always_comb begin
      ptr_d = ptr_q;
      if (advance && rr_mode && (s0_valid || s1_valid)) ptr_d = ~ptr_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) ptr_q <= SRC_S0;
      else      ptr_q <= ptr_d;
   end

endmodule

// File: rtl/i2s_tx_sched.sv
// i2s_tx_sched
//   Schedules samples from two sources onto an I2S serializer, one stereo
//   frame (left then right slot) per source grant.
//   Ports:
//     clk, rst   : clock, synchronous active-low reset
//     enable     : scheduler run enable (checked in IDLE/WAIT_REQ only)
//     rr_mode    : 0 = fixed priority, 1 = round-robin per frame
//     bus        : i2s_tx_sched_if master (sources + serializer side)
//     state_dbg  : current FSM state (ST_* encoding)
//     underrun_cnt : saturating underrun counter, present only when
//                    I2S_SCHED_UNDERRUN_CNT_EN is defined
//   A tx_req seen in WAIT_REQ yields tx_valid exactly two cycles later.
module i2s_tx_sched
   import i2s_sched_pkg::*;
#(
   parameter int I2S_DATA_BIT_WIDTH = DEF_DATA_W
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       rr_mode,
   i2s_tx_sched_if.master bus,
   output logic [1:0] state_dbg
`ifdef I2S_SCHED_UNDERRUN_CNT_EN
   ,
   output logic [15:0] underrun_cnt
`endif
);

   localparam int W = I2S_DATA_BIT_WIDTH;

   logic [1:0]   state_q, state_d;
   logic         chan_q, chan_d;
   logic [W-1:0] tx_data_q, tx_data_d;
   logic         tx_valid_q, tx_valid_d;
   logic         tx_left_q, tx_left_d;
   logic         frame_src_q, frame_src_d;
   logic         underrun_q, underrun_d;

   logic         arb_grant;
   logic         fetch_act;
   logic         left_commit;
   logic         slot_src;
   logic         src_valid;
   logic [W-1:0] src_data;

   // Gating with rst keeps a reset that lands in FETCH from completing
   // a source handshake in that same cycle.
   assign fetch_act   = rst && (state_q == ST_FETCH);
   assign left_commit = fetch_act && (chan_q == LEFT);

   // The grant is only re-evaluated for the left slot; the right slot
   // stays with whoever owns the frame.
   assign slot_src  = (chan_q == LEFT) ? arb_grant : frame_src_q;
   assign src_valid = (slot_src == SRC_S1) ? bus.s1_valid : bus.s0_valid;
   assign src_data  = (slot_src == SRC_S1) ? bus.s1_data  : bus.s0_data;

   i2s_src_arb u_arb (
      .clk        (clk),
      .rst        (rst),
      .rr_mode    (rr_mode),
      .s0_valid   (bus.s0_valid),
      .s1_valid   (bus.s1_valid),
      .prev_grant (frame_src_q),
      .advance    (left_commit),
      .grant      (arb_grant)
   );

   always_comb begin
      state_d     = state_q;
      chan_d      = chan_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = 1'b0;
      tx_left_d   = tx_left_q;
      frame_src_d = frame_src_q;
      underrun_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            chan_d = LEFT;
            if (enable) state_d = ST_WAIT_REQ;
         end
         ST_WAIT_REQ: begin
            if (!enable)          state_d = ST_IDLE;
            else if (bus.tx_req)  state_d = ST_FETCH;
         end
         ST_FETCH: begin
            state_d     = ST_SEND;
            tx_valid_d  = 1'b1;
            tx_data_d   = src_valid ? src_data : '0;
            underrun_d  = ~src_valid;
            tx_left_d   = (chan_q == LEFT);
            frame_src_d = slot_src;
         end
         ST_SEND: begin
            state_d = ST_WAIT_REQ;
            chan_d  = ~chan_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         chan_q      <= LEFT;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         tx_left_q   <= 1'b0;
         frame_src_q <= SRC_S0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         chan_q      <= chan_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         tx_left_q   <= tx_left_d;
         frame_src_q <= frame_src_d;
         underrun_q  <= underrun_d;
      end
   end

   assign bus.s0_ready  = fetch_act && (slot_src == SRC_S0);
   assign bus.s1_ready  = fetch_act && (slot_src == SRC_S1);
   assign bus.tx_data   = tx_data_q;
   assign bus.tx_valid  = tx_valid_q;
   assign bus.tx_left   = tx_left_q;
   assign bus.frame_src = frame_src_q;
   assign bus.underrun  = underrun_q;
   assign state_dbg     = state_q;

`ifdef I2S_SCHED_UNDERRUN_CNT_EN
   logic [15:0] ucnt_q, ucnt_d;

   // Counts alongside the underrun pulse so the value already reflects it
   // in the cycle tx_valid is seen.
   always_comb begin
      ucnt_d = ucnt_q;
      if (rst && underrun_d && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) ucnt_q <= 16'd0;
      else      ucnt_q <= ucnt_d;
   end

   assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx_sched.sv
// tb_i2s_tx_sched
//   Directed bench for i2s_tx_sched. Inputs change 1 ns after the rising
//   edge; outputs are sampled at the same point.
module tb_i2s_tx_sched;
   import i2s_sched_pkg::*;

   localparam int W = 24;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       rr_mode;
   logic [1:0] state_dbg;
`ifdef I2S_SCHED_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;
   int          exp_cnt;
`endif

   int n_checks;
   int n_fail;

   i2s_tx_sched_if #(.W(W)) bus ();

   i2s_tx_sched #(.I2S_DATA_BIT_WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .rr_mode   (rr_mode),
      .bus       (bus),
      .state_dbg (state_dbg)
`ifdef I2S_SCHED_UNDERRUN_CNT_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"},     32'(state_dbg),     32'(ST_IDLE));
      check({tag, "_tx_data"},   32'(bus.tx_data),   32'h0);
      check({tag, "_tx_valid"},  32'(bus.tx_valid),  32'h0);
      check({tag, "_tx_left"},   32'(bus.tx_left),   32'h0);
      check({tag, "_frame_src"}, 32'(bus.frame_src), 32'h0);
      check({tag, "_underrun"},  32'(bus.underrun),  32'h0);
      check({tag, "_s0_ready"},  32'(bus.s0_ready),  32'h0);
      check({tag, "_s1_ready"},  32'(bus.s1_ready),  32'h0);
`ifdef I2S_SCHED_UNDERRUN_CNT_EN
      check({tag, "_ucnt"},      32'(underrun_cnt),  32'h0);
`endif
   endtask

   // One slot, starting from WAIT_REQ: request, FETCH, SEND, back in WAIT_REQ.
   task automatic slot(input string tag, input logic [W-1:0] d, input logic l,
                       input logic src, input logic und, input logic r0, input logic r1);
      bus.tx_req = 1'b1;
      step();
      bus.tx_req = 1'b0;
      check({tag, "_fetch"},    32'(state_dbg),     32'(ST_FETCH));
      check({tag, "_s0_ready"}, 32'(bus.s0_ready),  32'(r0));
      check({tag, "_s1_ready"}, 32'(bus.s1_ready),  32'(r1));
      step();
      check({tag, "_valid"},    32'(bus.tx_valid),  32'h1);
      check({tag, "_data"},     32'(bus.tx_data),   32'(d));
      check({tag, "_left"},     32'(bus.tx_left),   32'(l));
      check({tag, "_src"},      32'(bus.frame_src), 32'(src));
      check({tag, "_under"},    32'(bus.underrun),  32'(und));
      check({tag, "_rdy_send"}, 32'({bus.s0_ready, bus.s1_ready}), 32'h0);
`ifdef I2S_SCHED_UNDERRUN_CNT_EN
      if (und) exp_cnt++;
`endif
      step();
      check({tag, "_valid_off"}, 32'(bus.tx_valid), 32'h0);
      check({tag, "_under_off"}, 32'(bus.underrun), 32'h0);
      check({tag, "_hold"},      32'(bus.tx_data),  32'(d));
      check({tag, "_wait"},      32'(state_dbg),    32'(ST_WAIT_REQ));
`ifdef I2S_SCHED_UNDERRUN_CNT_EN
      check({tag, "_ucnt"},      32'(underrun_cnt), 32'(exp_cnt));
`endif
   endtask

   initial begin
      int vcnt;
      n_checks = 0;
      n_fail   = 0;
`ifdef I2S_SCHED_UNDERRUN_CNT_EN
      exp_cnt  = 0;
`endif
      rst          = 1'b0;
      enable       = 1'b0;
      rr_mode      = 1'b0;
      bus.tx_req   = 1'b0;
      bus.s0_valid = 1'b0;
      bus.s1_valid = 1'b0;
      bus.s0_data  = '0;
      bus.s1_data  = '0;

      // reset state
      step(); step(); step();
      check_reset_outputs("reset");
      rst    = 1'b1;
      enable = 1'b1;
      step();
      check("en_wait", 32'(state_dbg), 32'(ST_WAIT_REQ));

      // fixed priority, s0 streaming
      bus.s0_valid = 1'b1;
      bus.s0_data  = 24'h123456;
      slot("fx_l", 24'h123456, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.s0_data  = 24'h345678;
      slot("fx_r", 24'h345678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // fixed priority, both valid: s1 never gets ready
      bus.s0_data  = 24'h111111;
      bus.s1_data  = 24'h222222;
      bus.s1_valid = 1'b1;
      slot("fxb_l", 24'h111111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      slot("fxb_r", 24'h111111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // round-robin: s0, s1, empty frame (owner kept), then s0 again
      rr_mode     = 1'b1;
      bus.s0_data = 24'h567890;
      bus.s1_data = 24'h789012;
      slot("rr1_l", 24'h567890, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      slot("rr1_r", 24'h567890, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      slot("rr2_l", 24'h789012, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      slot("rr2_r", 24'h789012, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      bus.s0_valid = 1'b0;
      bus.s1_valid = 1'b0;
      slot("rr3_l", 24'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      slot("rr3_r", 24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      bus.s0_valid = 1'b1;
      bus.s1_valid = 1'b1;
      slot("rr4_l", 24'h567890, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      slot("rr4_r", 24'h567890, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // owner drops out on the right slot; s1 valid must not take over
      rr_mode     = 1'b0;
      bus.s0_data = 24'h2468AC;
      bus.s1_data = 24'h13579B;
      slot("ur_l", 24'h2468AC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.s0_valid = 1'b0;
      slot("ur_r", 24'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

      // tx_req held through FETCH and SEND: only one strobe
      bus.s0_valid = 1'b1;
      bus.s1_valid = 1'b0;
      bus.s0_data  = 24'h0ABCDE;
      vcnt = 0;
      bus.tx_req = 1'b1;
      step();
      check("ign_fetch", 32'(state_dbg), 32'(ST_FETCH));
      vcnt += int'(bus.tx_valid);
      step();
      check("ign_send", 32'(state_dbg), 32'(ST_SEND));
      check("ign_data", 32'(bus.tx_data), 32'h0ABCDE);
      vcnt += int'(bus.tx_valid);
      step();
      bus.tx_req = 1'b0;
      check("ign_wait", 32'(state_dbg), 32'(ST_WAIT_REQ));
      for (int i = 0; i < 4; i++) begin
         vcnt += int'(bus.tx_valid);
         step();
      end
      check("ign_count", 32'(vcnt), 32'h1);

      // reset lands in FETCH of the right slot with s0 valid
      bus.s0_data = 24'hFEDCBA;
      bus.tx_req  = 1'b1;
      step();
      bus.tx_req  = 1'b0;
      check("rstf_fetch", 32'(state_dbg), 32'(ST_FETCH));
      rst = 1'b0;
      #1;
      check("rstf_s0_ready", 32'(bus.s0_ready), 32'h0);
      step();
      check_reset_outputs("rstf");
`ifdef I2S_SCHED_UNDERRUN_CNT_EN
      exp_cnt = 0;
`endif
      rst = 1'b1;
      step();
      check("rstf_wait", 32'(state_dbg), 32'(ST_WAIT_REQ));
      slot("rstf_l", 24'hFEDCBA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

      // enable dropped in FETCH: slot completes, then IDLE restarts on left
      bus.s0_data = 24'h0F0F0F;
      bus.tx_req  = 1'b1;
      step();
      bus.tx_req  = 1'b0;
      enable      = 1'b0;
      step();
      check("en_valid", 32'(bus.tx_valid), 32'h1);
      check("en_left",  32'(bus.tx_left),  32'h0);
      check("en_data",  32'(bus.tx_data),  32'h0F0F0F);
      step();
      check("en_wait2", 32'(state_dbg), 32'(ST_WAIT_REQ));
      step();
      check("en_idle", 32'(state_dbg), 32'(ST_IDLE));
      bus.tx_req = 1'b1;
      step();
      check("idle_req_ign", 32'(state_dbg), 32'(ST_IDLE));
      check("idle_no_valid", 32'(bus.tx_valid), 32'h0);
      bus.tx_req = 1'b0;
      enable     = 1'b1;
      step();
      check("idle_to_wait", 32'(state_dbg), 32'(ST_WAIT_REQ));
      bus.s0_data = 24'hA5A5A5;
      slot("idle_l", 24'hA5A5A5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2s_tx_sched.md
I2S_TX_SCHED -- requirements
Module: i2s_tx_sched

Interface
REQ-001 SHALL have parameter I2S_DATA_BIT_WIDTH, default 24, sample width.
REQ-002 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port enable  in  1  scheduler run enable.
REQ-005 SHALL have port rr_mode  in  1  0 = fixed priority (s0 first), 1 = round-robin per stereo frame.
REQ-006 SHALL have ports s0_data/s1_data  in  I2S_DATA_BIT_WIDTH  source samples.
REQ-007 SHALL have ports s0_valid/s1_valid  in  1  source sample available.
REQ-008 SHALL have ports s0_ready/s1_ready  out  1  sample accepted when valid&ready.
REQ-009 SHALL have port tx_req  in  1  serializer request for next slot sample, one-cycle pulse.
REQ-010 SHALL have port tx_data  out  I2S_DATA_BIT_WIDTH  sample to serializer.
REQ-011 SHALL have port tx_valid  out  1  one-cycle strobe, tx_data valid.
REQ-012 SHALL have port tx_left  out  1  1 = tx_data is left slot, 0 = right.
REQ-013 SHALL have port frame_src  out  1  source owning current frame (0 = s0, 1 = s1).
REQ-014 SHALL have port underrun  out  1  one-cycle pulse when a slot is served without source data.

Function
REQ-015 SHALL implement states IDLE, WAIT_REQ, FETCH, SEND.
REQ-016 IDLE -> WAIT_REQ when enable=1; WAIT_REQ -> IDLE when enable=0; WAIT_REQ -> FETCH on tx_req=1; FETCH -> SEND always; SEND -> WAIT_REQ always.
REQ-017 Latency: tx_req high in cycle c SHALL give tx_valid high in cycle c+2, exactly one cycle.
REQ-018 tx_req during FETCH, SEND or IDLE SHALL be ignored.
REQ-019 Frame = left slot then right slot; channel SHALL start left after reset and after every IDLE, then toggle on each SEND.
REQ-020 Grant SHALL be decided in FETCH of the left slot only; the right slot SHALL use the same source.
REQ-021 Fixed priority: s0 if s0_valid, else s1 if s1_valid, else keep previous grant.
REQ-022 Round-robin: preferred source alternates each frame; take preferred if valid, else the other if valid; pointer advances only when a frame is granted to a valid source.
REQ-023 In FETCH, ready SHALL be high for the granted source only, and low in all other states.
REQ-024 If the granted source is valid in FETCH, data SHALL be latched into tx_data at the FETCH->SEND edge.
REQ-025 If the granted source is not valid, tx_data SHALL be 0, tx_valid still SHALL pulse, and underrun SHALL pulse together with tx_valid.
REQ-026 tx_data, tx_left and frame_src SHALL hold their values between SEND cycles.
REQ-027 enable=0 during FETCH/SEND SHALL NOT abort the slot; it takes effect in WAIT_REQ.

Reset
REQ-028 rst=0 SHALL force IDLE, channel left, RR pointer to s0, and all outputs 0 (tx_data=0, tx_valid=0, tx_left=0, frame_src=0, ready=0, underrun=0).
REQ-029 Reset mid-FETCH SHALL drop the pending transfer; no source handshake SHALL complete in that cycle.

Configuration
REQ-030 Macro I2S_SCHED_UNDERRUN_CNT_EN defined: SHALL add output underrun_cnt, 16 bits, incremented per underrun pulse, saturating at 16'hFFFF, cleared by reset.
REQ-031 Macro I2S_SCHED_UNDERRUN_CNT_EN undefined: no port and no counter logic; all other behaviour identical.

Structure
REQ-032 Package i2s_sched_pkg SHALL hold the state encoding, the channel constants LEFT/RIGHT and the default sample width.
REQ-033 Sub-module i2s_src_arb SHALL implement the 2-way fixed/round-robin grant (REQ-021, REQ-022) with its pointer register.

Verification
REQ-034 Fixed mode, s0 streams 24'h123456, 24'h345678; tx_req pulses -> tx_data 24'h123456 left, then 24'h345678 right, each at c+2, frame_src=0.
REQ-035 Fixed mode, s0 and s1 both always valid -> s1_ready never asserted.
REQ-036 RR mode, both valid, s0=24'h567890, s1=24'h789012 -> frames alternate s0, s1, s0; pointer does not advance on a frame where both sources are invalid.
REQ-037 Granted source invalid on right slot -> tx_data 0, underrun pulse, tx_left=0; with macro, underrun_cnt=1.
REQ-038 tx_req pulses in FETCH and in SEND -> ignored, exactly one tx_valid per accepted request.
REQ-039 rst=0 asserted in FETCH with s0_valid=1 -> no s0 transfer, all outputs 0; next frame starts left.
